// File: rtl/result_reader_pkg.sv
// Shared types for the result memory reader: FSM state encoding and address-width helper.
package result_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAP,
    OUT,
    FIN
  } rr_state_e;

  function automatic int rr_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/result_reader_if.sv
// Control, memory-read and stream signals of the result reader; master is the
// environment (memory + consumer), slave is the reader itself.
interface result_reader_if
  import result_reader_pkg::*;
#(
  parameter int MEM_DEPTH = 8,
  parameter int MEM_WIDTH = 32
);
  localparam int AW = rr_aw(MEM_DEPTH);

  logic                 start_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 rd_en_o;
  logic [AW-1:0]        rd_addr_o;
  logic [MEM_WIDTH-1:0] rd_data_i;
  logic [MEM_WIDTH-1:0] data_o;
  logic [AW-1:0]        idx_o;
  logic                 valid_o;
  logic                 ready_i;
  logic [MEM_WIDTH-1:0] chksum_o;

  modport master (
    output start_i, rd_data_i, ready_i,
    input  busy_o, done_o, rd_en_o, rd_addr_o, data_o, idx_o, valid_o, chksum_o
  );

  modport slave (
    input  start_i, rd_data_i, ready_i,
    output busy_o, done_o, rd_en_o, rd_addr_o, data_o, idx_o, valid_o, chksum_o
  );

endinterface

// File: rtl/result_reader_out_reg.sv
// Output holding register: captures one word plus its index on load and keeps it
// stable with valid raised until the downstream handshake completes.
module result_reader_out_reg #(
  parameter int W  = 32,
  parameter int AW = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load,
  input  logic          ready,
  input  logic [W-1:0]  data_in,
  input  logic [AW-1:0] idx_in,
  output logic [W-1:0]  data,
  output logic [AW-1:0] idx,
  output logic          valid
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data  <= '0;
      idx   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= data_in;
      idx   <= idx_in;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/result_reader.sv
// Walks the result memory 0..MEM_DEPTH-1 and streams each word with its index.
// Optional XOR checksum of accepted words: define RESULT_READER_CHKSUM_EN.
module result_reader
  import result_reader_pkg::*;
#(
  parameter int MEM_DEPTH = 8,
  parameter int MEM_WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  result_reader_if.slave bus
);

  localparam int            AW   = rr_aw(MEM_DEPTH);
  localparam logic [AW-1:0] LAST = AW'(MEM_DEPTH - 1);

  rr_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_addr_q;
  logic          load;
  logic          accept;
  logic          pass_start;

  assign accept = (state_q == OUT) && bus.valid_o && bus.ready_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    pass_start = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start_i) begin
        state_d    = REQ;
        cnt_d      = '0;
        pass_start = 1'b1;
      end
      REQ:  state_d = CAP;
      CAP: begin
        load    = 1'b1;
        state_d = OUT;
      end
      OUT: if (accept) begin
        // Counter parks on the last index; the pass ends instead of wrapping.
        if (cnt_q == LAST) state_d = FIN;
        else begin
          cnt_d   = cnt_q + AW'(1);
          state_d = REQ;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Address only moves when entering REQ, so it holds outside the strobe.
      if (state_d == REQ) rd_addr_q <= cnt_d;
    end
  end

  assign bus.busy_o    = (state_q != IDLE);
  assign bus.done_o    = (state_q == FIN);
  assign bus.rd_en_o   = (state_q == REQ);
  assign bus.rd_addr_o = rd_addr_q;

  result_reader_out_reg #(
    .W  (MEM_WIDTH),
    .AW (AW)
  ) u_out_reg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load    (load),
    .ready   (bus.ready_i),
    .data_in (bus.rd_data_i),
    .idx_in  (cnt_q),
    .data    (bus.data_o),
    .idx     (bus.idx_o),
    .valid   (bus.valid_o)
  );

`ifdef RESULT_READER_CHKSUM_EN
  logic [MEM_WIDTH-1:0] chksum_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         chksum_q <= '0;
    else if (pass_start) chksum_q <= '0;
    else if (accept)     chksum_q <= chksum_q ^ bus.data_o;
  end

  assign bus.chksum_o = chksum_q;
`else
  assign bus.chksum_o = '0;
`endif

endmodule

// File: doc/result_reader.md
Name: result_reader

Overview:
- Read-side counterpart of the block that writes the result memory.
- On start, reads all MEM_DEPTH entries of a synchronous-read result memory in order, from address 0 to MEM_DEPTH-1.
- Streams each word out on a valid/ready interface together with its index.
- Lets downstream checkers and DPI scoreboards consume results without reaching into memory internals hierarchically.

Parameters:
- MEM_DEPTH, 8, number of result words; must be ≥2.
- MEM_WIDTH, 32, width of a result word in bits.
- Local AW = $clog2(MEM_DEPTH).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  begin a read pass; honoured only in IDLE.
- busy_o  output  1  high in any state other than IDLE.
- done_o  output  1  one-cycle pulse after the last word is accepted.
- rd_en_o  output  1  memory read strobe.
- rd_addr_o  output  AW  memory read address.
- rd_data_i  input  MEM_WIDTH  memory read data, valid exactly 1 cycle after rd_en_o.
- data_o  output  MEM_WIDTH  streamed word.
- idx_o  output  AW  address of data_o.
- valid_o  output  1  data_o/idx_o valid.
- ready_i  input  1  downstream accepts when valid_o && ready_i.
- chksum_o  output  MEM_WIDTH  running checksum (see Optional Feature).

Behaviour:
- Reset (async, rst_ni=0):
  - State goes to IDLE; address counter is 0.
  - All outputs are 0: busy_o, done_o, rd_en_o, rd_addr_o, data_o, idx_o, valid_o, chksum_o.
  - Reset mid-pass aborts the pass immediately; no done_o pulse.
- States: IDLE, REQ, CAP, OUT, FIN.
- IDLE:
  - start_i=1 → REQ, counter cleared to 0.
  - start_i=0 → stay in IDLE.
- REQ:
  - rd_en_o=1, rd_addr_o=counter for exactly this one cycle.
  - Next state CAP.
- CAP:
  - rd_data_i is registered into data_o and counter into idx_o.
  - Next state OUT.
- OUT:
  - valid_o=1; data_o and idx_o are held stable until the handshake.
  - valid_o && ready_i with counter==MEM_DEPTH-1 → FIN.
  - valid_o && ready_i otherwise → counter+1, then REQ.
  - ready_i=0 → stay in OUT indefinitely.
- FIN:
  - done_o=1 for this single cycle.
  - Next state IDLE.
- rd_en_o is 0 and rd_addr_o holds its last value outside REQ.
- valid_o is deasserted the cycle after acceptance.
- Latency: start_i accepted at edge N → rd_en_o high in cycle N+1 → valid_o high from cycle N+3.
- Throughput is at best 1 word per 3 cycles when ready_i is held high.
- A full pass with ready_i held high takes 3*MEM_DEPTH+1 cycles from start to done_o.
- start_i while busy_o=1 is ignored; there is no restart.
- start_i in the FIN cycle is ignored. Only start_i seen in IDLE starts a pass.
- Counter saturates at MEM_DEPTH-1; it never wraps within a pass. A new pass starts again from 0.
- ready_i without valid_o has no effect.

Optional Feature:
- Macro: RESULT_READER_CHKSUM_EN.
- Defined:
  - chksum_o is cleared to 0 when a pass starts.
  - On each accepted word, chksum_o ← chksum_o XOR data_o.
  - chksum_o is final and stable from the done_o cycle until the next start.
- Undefined: chksum_o is tied to 0 and no accumulator register exists. The port stays present so the port list never changes.

Decomposition:
- Package result_reader_pkg:
  - State enum typedef (IDLE, REQ, CAP, OUT, FIN).
  - Localparam helper for the address width.
- One sub-module is natural: result_reader_out_reg, the output holding register. It loads data_o/idx_o on a load pulse, sets valid_o, and clears valid_o on handshake.
- The FSM and counter stay in the top block.

Test Plan:
- Basic pass:
  - Stimulus: memory preloaded mem[i]=i*3+1, ready_i=1, start_i pulsed.
  - Required: words 1,4,7,10,13,16,19,22 with idx 0..7 in order; done_o pulses exactly once, 25 cycles after start acceptance.
- Backpressure:
  - Stimulus: ready_i=0 for 5 cycles while word idx=2 is valid.
  - Required: data_o=7, idx_o=2 and valid_o held unchanged for all 5 cycles; no rd_en_o pulse until acceptance; the next word is 10.
- Start while busy:
  - Stimulus: start_i pulsed again during the idx=4 word.
  - Required: ignored; the sequence continues 13,16,19,22 and done_o pulses once.
- Reset mid-pass:
  - Stimulus: rst_ni=0 asynchronously during CAP of idx=5.
  - Required: all outputs 0 in the same cycle; no done_o; the next start re-reads from idx 0.
- Checksum (RESULT_READER_CHKSUM_EN defined):
  - Stimulus: mem={0x1,0x2,0x4,0x8,0x10,0x20,0x40,0x80}.
  - Required: chksum_o=0xFF at done_o.
  - Undefined build: chksum_o=0 throughout.
- Back-to-back passes:
  - Stimulus: start_i issued the cycle after FIN.
  - Required: accepted in IDLE; the second pass is identical to the first, and chksum_o restarts from 0.
